// File: rtl/feature_pingpong_buf_if.sv
// rtl/feature_pingpong_buf_if.sv - stream input, bank status and read port bundle for the ping-pong buffer
interface feature_pingpong_buf_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] stream_rx_data;
  logic              stream_feature_vld;
  logic              write_finish;
  logic              buf_ready;
  logic [1:0]        bank_full;
  logic              overflow;
  logic              rd_avail;
  logic [ADDR_W:0]   rd_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic              rd_release;

  modport master (
    output stream_rx_data, stream_feature_vld, write_finish, rd_en, rd_addr, rd_release,
    input  buf_ready, bank_full, overflow, rd_avail, rd_len, rd_data, rd_data_vld
  );

  modport slave (
    input  stream_rx_data, stream_feature_vld, write_finish, rd_en, rd_addr, rd_release,
    output buf_ready, bank_full, overflow, rd_avail, rd_len, rd_data, rd_data_vld
  );
endinterface

// File: rtl/feature_pingpong_buf.sv
// rtl/feature_pingpong_buf.sv - two-bank ping-pong feature buffer between stream receive and conv engine
module feature_pingpong_buf #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic                  sclk,
  input  logic                  s_rst,
  feature_pingpong_buf_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        full;
  logic [ADDR_W:0]   len0;
  logic [ADDR_W:0]   len1;
  logic              overflow_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  logic accept;
  logic close;
  logic release_ok;
  logic read_ok;

  // write_finish only closes a bank when it rides on an accepted feature beat
  assign accept     = bus.stream_feature_vld & ~full[wr_bank];
  assign close      = accept & ((wr_addr == ADDR_W'(DEPTH - 1)) | bus.write_finish);
  assign release_ok = bus.rd_release & full[rd_bank];
  assign read_ok    = bus.rd_en & full[rd_bank];

  assign bus.buf_ready   = ~full[wr_bank];
  assign bus.bank_full   = full;
  assign bus.overflow    = overflow_q;
  assign bus.rd_avail    = full[rd_bank];
  assign bus.rd_len      = rd_bank ? len1 : len0;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_data_vld = rd_vld_q;

  // Storage has no reset so it maps onto block RAM
  always_ff @(posedge sclk) begin
    if (!s_rst && accept) begin
      if (wr_bank) mem1[wr_addr] <= bus.stream_rx_data;
      else         mem0[wr_addr] <= bus.stream_rx_data;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_addr    <= '0;
      full       <= 2'b00;
      len0       <= '0;
      len1       <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      if (close) begin
        full[wr_bank] <= 1'b1;
        if (wr_bank) len1 <= {1'b0, wr_addr} + (ADDR_W + 1)'(1);
        else         len0 <= {1'b0, wr_addr} + (ADDR_W + 1)'(1);
        wr_bank <= ~wr_bank;
        wr_addr <= '0;
      end else if (accept) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      // Close and release always hit different banks, so both bit writes coexist
      if (release_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end

      if (bus.stream_feature_vld && full[wr_bank]) overflow_q <= 1'b1;

      rd_vld_q <= read_ok;
      if (read_ok) rd_data_q <= rd_bank ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
    end
  end
endmodule
